alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//  Parametrised, handshaked successor to the single-cycle datapath ALU. Sits between decode/operand fetch and
//  writeback. Registers the result and the flags, accepts one op per cycle, and adds shifts, XOR, SLTU and an
//  optional iterative multiply that stalls the input side while it runs.
// PARAMETERS
//  WIDTH     32               operand/result width; power of 2, >=8
//  SHW       $clog2(WIDTH)    shift-amount width, derived; do not override
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands+op present
//  in_ready   out  1      block can accept this cycle
//  a_in       in   WIDTH  operand A
//  b_in       in   WIDTH  operand B (shift amount = b_in[SHW-1:0])
//  alu_sel    in   4      opcode
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes result
//  alu_out    out  WIDTH  result
//  zero       out  1      alu_out==0
//  carry_out  out  1      ADD: carry out of MSB; SUB: no-borrow (a>=b unsigned); else 0
//  overflow   out  1      ADD/SUB signed overflow; else 0
//  illegal    out  1      opcode not supported in this build
// BEHAVIOUR
//  Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SLL, 0101 SRL, 1101 SRA, 0110 SUB, 0111 SLT(signed),
//   1000 SLTU, 1100 NOR, 1111 EQ, 1001 MUL (low WIDTH bits). Any other code: ADD, illegal=0.
//  Compare ops return 1/0 zero-extended. ADD ovf = a,b same sign & result sign differs; SUB ovf = a,b signs differ
//   & result sign != a sign. Arithmetic is modulo 2^WIDTH.
//  Reset: out_valid=0, alu_out=0, zero=0, carry_out=0, overflow=0, illegal=0, FSM=IDLE. in_ready reflects state
//   combinationally: 1 out of reset.
//  Handshake: transfer on valid&ready, both sides. in_ready = (state==IDLE) & (~out_valid | out_ready).
//   Output regs hold stable while out_valid & ~out_ready. Simultaneous output pop and input accept is legal and
//   gives full throughput. in_valid may drop without a transfer; a_in/b_in/alu_sel are sampled only on transfer.
//  Latency: non-MUL ops 1 cycle (out_valid the cycle after accept).
//  FSM: IDLE -accept MUL-> MUL (WIDTH iterations, 1 bit/cycle) -> IDLE, loading the output regs on the last
//   iteration. MUL latency = WIDTH cycles; in_ready=0 throughout MUL. MUL flags: carry/overflow=0, zero from result.
//  rst_n low at any time (including mid-MUL) aborts: partial product discarded, all regs to reset values.
// CONFIGURATION
//  ALU_MUL_EN defined: MUL implemented as above.
//  ALU_MUL_EN undefined: no multiplier logic, FSM stays IDLE. MUL completes in 1 cycle with alu_out=0,
//   zero=1, illegal=1. illegal is 0 for every other opcode in both builds.
// STRUCTURE
//  alu_pkg: opcode localparams (ALU_AND..ALU_MUL), FSM state encoding (ST_IDLE, ST_MUL), flag bit indices.
//  Sub-module alu_mul_iter (WIDTH): shift-add multiplier with start/busy/done and a SHW+1-bit iteration counter.
//   Instantiated only under ALU_MUL_EN.
//  Combinational op mux + flag logic live in alu_pipe. One output register stage. No other state.
// TESTING (WIDTH=32)
//  ADD 0x7FFFFFFF+0x1 -> 0x80000000, overflow=1, carry=0, zero=0, out_valid exactly 1 cycle after accept.
//  SUB 5-5 -> 0, zero=1, carry=1. SUB 0-1 -> 0xFFFFFFFF, carry=0, overflow=0.
//  SLT 0xFFFFFFFF,1 -> 1. SLTU same operands -> 0. SRA 0x80000000 by 4 -> 0xF8000000.
//   SRL same -> 0x08000000. Shift by b=0x24 uses amount 4.
//  Back-to-back ops with out_ready held 0 for 3 cycles: outputs stable, in_ready=0, no lost/duplicate results.
//   Then 1 result/cycle streaming with out_ready=1.
//  MUL 7*0xFFFFFFFF (ALU_MUL_EN) -> 0xFFFFFFF9 after 32 cycles, in_ready=0 meanwhile.
//   Without ALU_MUL_EN -> 0, illegal=1, 1-cycle latency.
//  rst_n asserted 10 cycles into a MUL: out_valid=0 immediately. After release in_ready=1, and the next ADD 2+3
//   returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Opcodes, FSM state encoding and flag bit indices shared by alu_pipe and its bench.
// ALU_MUL_EN selects whether ALU_MUL is implemented or reported as illegal.
package alu_pkg;

  localparam int unsigned OP_W = 4;

  localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [OP_W-1:0] ALU_XOR  = 4'b0011;
  localparam logic [OP_W-1:0] ALU_SLL  = 4'b0100;
  localparam logic [OP_W-1:0] ALU_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [OP_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [OP_W-1:0] ALU_SLTU = 4'b1000;
  localparam logic [OP_W-1:0] ALU_MUL  = 4'b1001;
  localparam logic [OP_W-1:0] ALU_NOR  = 4'b1100;
  localparam logic [OP_W-1:0] ALU_SRA  = 4'b1101;
  localparam logic [OP_W-1:0] ALU_EQ   = 4'b1111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  localparam int unsigned FLG_ZERO  = 0;
  localparam int unsigned FLG_CARRY = 1;
  localparam int unsigned FLG_OVF   = 2;
  localparam int unsigned FLG_ILL   = 3;
  localparam int unsigned FLG_W     = 4;

  typedef logic [FLG_W-1:0] flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier, one multiplier bit per cycle, low WIDTH product bits only.
// Only instantiated by alu_pipe when ALU_MUL_EN is defined.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_c
);

  localparam int unsigned SHW   = $clog2(WIDTH);
  localparam int unsigned CNT_W = SHW + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;

  // Final bit is folded in combinationally so the owner can load it on the last iteration.
  assign product_c = acc + (mplier[0] ? mcand : '0);
  assign done      = busy & (cnt == LAST);

  // The start cycle already consumes multiplier bit 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= b[0] ? a : '0;
      mcand  <= a << 1;
      mplier <= b >> 1;
      cnt    <= CNT_W'(1);
      busy   <= 1'b1;
    end else if (busy) begin
      if (done) begin
        busy <= 1'b0;
      end else begin
        acc    <= product_c;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with one registered result/flag stage between operand fetch and writeback.
// Define ALU_MUL_EN to build the iterative multiplier; without it MUL returns 0 and flags illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       alu_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0] res_c;
  flags_t           flags_c;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             add_ovf;
  logic             sub_ovf;

  assign accept   = in_valid & in_ready;
  assign shamt    = b_in[SHW-1:0];
  assign add_full = {1'b0, a_in} + {1'b0, b_in};
  assign sub_full = {1'b0, a_in} - {1'b0, b_in};
  assign add_ovf  = (a_in[WIDTH-1] == b_in[WIDTH-1]) & (add_full[WIDTH-1] != a_in[WIDTH-1]);
  assign sub_ovf  = (a_in[WIDTH-1] != b_in[WIDTH-1]) & (sub_full[WIDTH-1] != a_in[WIDTH-1]);

`ifdef ALU_MUL_EN
  assign mul_start = accept & (alu_sel == ALU_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (mul_start),
    .a        (a_in),
    .b        (b_in),
    .busy     (mul_busy),
    .done     (mul_done),
    .product_c(mul_prod)
  );
`else
  assign mul_start = 1'b0;
  assign mul_busy  = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_prod  = '0;
`endif

  // Op mux and flags; ADD shares the default arm with the unassigned opcodes.
  always_comb begin
    res_c   = add_full[WIDTH-1:0];
    flags_c = '0;
    case (alu_sel)
      ALU_AND:  res_c = a_in & b_in;
      ALU_OR:   res_c = a_in | b_in;
      ALU_XOR:  res_c = a_in ^ b_in;
      ALU_NOR:  res_c = ~(a_in | b_in);
      ALU_SLL:  res_c = a_in << shamt;
      ALU_SRL:  res_c = a_in >> shamt;
      ALU_SRA:  res_c = WIDTH'($signed(a_in) >>> shamt);
      ALU_SLT:  res_c = WIDTH'($signed(a_in) < $signed(b_in));
      ALU_SLTU: res_c = WIDTH'(a_in < b_in);
      ALU_EQ:   res_c = WIDTH'(a_in == b_in);
      ALU_SUB: begin
        res_c              = sub_full[WIDTH-1:0];
        flags_c[FLG_CARRY] = ~sub_full[WIDTH];
        flags_c[FLG_OVF]   = sub_ovf;
      end
      ALU_MUL: begin
        res_c = '0;
`ifndef ALU_MUL_EN
        flags_c[FLG_ILL] = 1'b1;
`endif
      end
      default: begin
        res_c              = add_full[WIDTH-1:0];
        flags_c[FLG_CARRY] = add_full[WIDTH];
        flags_c[FLG_OVF]   = add_ovf;
      end
    endcase
    flags_c[FLG_ZERO] = (res_c == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (mul_start) state_nxt = ST_MUL;
      ST_MUL:  if (mul_done || !mul_busy) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Input side stalls for the whole multiply and whenever the held result cannot leave.
  always_comb begin
    in_ready = (state == ST_IDLE) & (~out_valid | out_ready);
  end

  // Output stage: a new result may replace a popped one in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      alu_out   <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept && !mul_start) begin
      out_valid <= 1'b1;
      alu_out   <= res_c;
      zero      <= flags_c[FLG_ZERO];
      carry_out <= flags_c[FLG_CARRY];
      overflow  <= flags_c[FLG_OVF];
      illegal   <= flags_c[FLG_ILL];
    end else if (mul_done) begin
      out_valid <= 1'b1;
      alu_out   <= mul_prod;
      zero      <= (mul_prod == '0);
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
